fpu_seq_ctrl: RTL

//  Sequencer between the instruction decoder and the multi-cycle FPU datapath.

---
 rtl/fpu_seq_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/fpu_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : fpu_seq_ctrl                                                 |
// | Description : Decoder-to-FPU sequencer. Issues one start pulse, stalls    |
// |               fetch until done, writes back once; watchdog aborts hangs.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module fpu_seq_ctrl #(
   parameter int OPW     = 3,
   parameter int AW      = 5,
   parameter int TIMEOUT = 64,
   parameter int CW      = 7
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           fp_req,
   input  logic [OPW-1:0] fp_op,
   input  logic [AW-1:0]  fp_fd,
   input  logic           fpu_done,
   input  logic           err_clr,
   output logic           fpu_start,
   output logic [OPW-1:0] fpu_op,
   output logic           stall,
   output logic           fp_regWrite,
   output logic [AW-1:0]  fp_wa,
   output logic           fpu_err
);

   localparam logic [1:0] c_st_idle  = 2'd0;
   localparam logic [1:0] c_st_issue = 2'd1;
   localparam logic [1:0] c_st_wait  = 2'd2;
   localparam logic [1:0] c_st_wb    = 2'd3;

   localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT - 1);

   logic [1:0]     r_state;
   logic [1:0]     w_state_nxt;
   logic [OPW-1:0] r_op;
   logic [AW-1:0]  r_wa;
   logic [CW-1:0]  r_cnt;
   logic           r_err;
   logic           w_accept;
   logic           w_timeout;

   assign w_accept  = (r_state == c_st_idle) && fp_req;
   // A done pulse in the final watchdog cycle still completes the op.
   assign w_timeout = (r_state == c_st_wait) && !fpu_done && (r_cnt == c_cnt_last);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle:  if (fp_req) w_state_nxt = c_st_issue;
         c_st_issue: w_state_nxt = c_st_wait;
         c_st_wait: begin
            if (fpu_done)       w_state_nxt = c_st_wb;
            else if (w_timeout) w_state_nxt = c_st_idle;
         end
         default:    w_state_nxt = c_st_idle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_st_idle;
         r_op    <= '0;
         r_wa    <= '0;
         r_cnt   <= '0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_op <= fp_op;
            r_wa <= fp_fd;
         end
         if (r_state == c_st_issue)
            r_cnt <= '0;
         else if (r_state == c_st_wait)
            r_cnt <= r_cnt + 1'b1;
         if (w_timeout)
            r_err <= 1'b1;
         else if (err_clr)
            r_err <= 1'b0;
      end
   end

   // Stall is combinational in IDLE so the requesting instruction is held
   // in the same cycle; it drops in WB so the PC advances on that edge.
   assign stall       = (r_state == c_st_idle) ? (fp_req & rst_n) : (r_state != c_st_wb);
   assign fpu_start   = (r_state == c_st_issue);
   assign fp_regWrite = (r_state == c_st_wb);
   assign fpu_op      = r_op;
   assign fp_wa       = r_wa;
   assign fpu_err     = r_err;

endmodule
`default_nettype wire
